vend_ctrl_param: RTL and testbench
==================================

Name: vend_ctrl_param

Overview:
Parametrised successor of the single-product-pair vending FSM. It supports N_DRINK products with per-product prices set by parameter. It adds coin rejection on overflow, an inactivity auto-refund timeout, and an explicit buy strobe. The block sits between the coin/button front end and the indicator/LED/display layer. All money values are Q1 fixed point (q = yuan*2).

Parameters:
SUM_W, 8, width of coin_sum and all money values (Q1).
N_DRINK, 2, number of products.
PRICE_VEC, {8'd10,8'd5}, packed prices; product i occupies [i*SUM_W +: SUM_W]; defaults are 2.5 and 5 yuan.
MAX_SUM, 40, largest accepted credit (20 yuan).
DISP_CYC, 4, cycles that drinktk_ind / charge_ind are held.
TIMEOUT_CYC, 0, idle cycles in COLLECT before auto-refund; 0 disables the timeout.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
insert  in  1  coin strobe, one cycle.
coin_val  in  2  coin type: 00=0.5 (q1), 01=1 (q2), 10=5 (q10), 11=10 (q20).
drink_op  in  $clog2(N_DRINK) (min 1)  product select, sampled with buy.
buy  in  1  purchase strobe, one cycle.
cancel_flag  in  1  cancel strobe, one cycle.
hold_ind  out  1  machine occupied (state != IDLE).
drink_ind  out  N_DRINK  bit i=1 when in COLLECT and coin_sum >= price i.
drinktk_ind  out  1  take-drink indicator.
charge_ind  out  1  take-change/refund indicator.
coin_rej  out  1  one-cycle pulse: coin returned.
coin_sum  out  SUM_W  credit, or change/refund amount in CHANGE.

Behaviour:
- Reset: state IDLE; coin_sum=0; timer=0; all indicators and coin_rej = 0. Reset mid-transaction discards credit.
- States: IDLE, COLLECT, VEND, CHANGE. Outputs are registered. drink_ind is decoded from the registered state and sum, so it is valid the cycle after a sum update.
- IDLE/COLLECT, insert:
  - If sum+v <= MAX_SUM: sum <= sum+v; state -> COLLECT; timer reloads.
  - Otherwise: coin_rej=1 for one cycle; sum unchanged.
  - The addition is done at SUM_W+1 bits, so it never wraps.
- COLLECT, buy with drink_op < N_DRINK and sum >= price: sum <= sum-price; state -> VEND.
  - Invalid or unaffordable buy is ignored.
  - buy or cancel in IDLE is ignored.
- VEND: drinktk_ind=1 for exactly DISP_CYC cycles. Then -> CHANGE if sum > 0, else -> IDLE.
- COLLECT, cancel_flag: state -> CHANGE with the full sum (refund).
- Timeout: if TIMEOUT_CYC > 0 and there is no accepted insert or buy for TIMEOUT_CYC consecutive COLLECT cycles, behave as cancel.
- CHANGE: charge_ind=1 and coin_sum shows the amount for DISP_CYC cycles; then sum <= 0 and state -> IDLE.
- Same-cycle priority: cancel_flag > buy > insert.
  - An insert that loses to cancel or buy is rejected (coin_rej pulse).
  - insert during VEND or CHANGE is rejected.
  - buy and cancel during VEND or CHANGE are ignored.

Optional Feature:
CHANGE_PAYOUT_EN.
- With the macro defined: extra outputs pay_1 and pay_half (1 bit each). In CHANGE, one coin is paid per cycle:
  - pay_1 while sum >= 2, with sum -= 2;
  - otherwise pay_half, with sum -= 1.
  - charge_ind stays high throughout.
  - State -> IDLE the cycle after sum reaches 0; DISP_CYC is not used in CHANGE.
- Without the macro: the ports are absent and CHANGE holds for DISP_CYC cycles as described above.

Decomposition:
- Package vend_pkg holds:
  - the state enum;
  - coin Q1 constants (Q_HALF=1, Q_ONE=2, Q_FIVE=10, Q_TEN=20);
  - the function coin_q(coin_val).
- Sub-module vend_timer: a loadable down-counter with a zero flag. Two instances are used: one for DISP_CYC and one for TIMEOUT_CYC.

Test Plan:
- Reset, insert 01 x3 (sum 6) -> drink_ind=01; buy op0 -> drinktk_ind 4 cycles, then CHANGE with coin_sum=1, charge_ind 4 cycles, then IDLE with sum 0.
- Insert 10 (sum 10), buy op1 -> drinktk_ind 4 cycles, no CHANGE, IDLE; hold_ind falls the same cycle.
- Insert 11,11 (sum 40), insert 00 -> coin_rej 1 cycle, sum stays 40.
- Insert 01, then assert cancel_flag and buy in the same cycle -> CHANGE with coin_sum=2; the buy is ignored.
- TIMEOUT_CYC=16: insert 01, idle 16 cycles -> CHANGE with coin_sum=2; an insert at cycle 10 restarts the count; an insert during CHANGE gives coin_rej.
- CHANGE_PAYOUT_EN: sum 15, buy op1 -> change 5 paid as pay_1, pay_1, pay_half on consecutive cycles, then IDLE.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared state encoding and coin valuation (Q1: one LSB = 0.5 yuan) for the vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_t;

  localparam logic [4:0] Q_HALF = 5'd1;
  localparam logic [4:0] Q_ONE  = 5'd2;
  localparam logic [4:0] Q_FIVE = 5'd10;
  localparam logic [4:0] Q_TEN  = 5'd20;

  function automatic logic [4:0] coin_q(input logic [1:0] coin_val);
    case (coin_val)
      2'b00:   coin_q = Q_HALF;
      2'b01:   coin_q = Q_ONE;
      2'b10:   coin_q = Q_FIVE;
      default: coin_q = Q_TEN;
    endcase
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter that parks at zero; zero flags expiry of a display or idle interval.
module vend_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // NOTE: registers use non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)                cnt_q <= '0;
    else if (load)          cnt_q <= load_val;
    else if (cnt_q != '0)   cnt_q <= cnt_q - W'(1);
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: N_DRINK products, overflow coin rejection, optional idle refund.
// Define CHANGE_PAYOUT_EN to pay change coin by coin on pay_1 / pay_half instead of a timed display.
module vend_ctrl_param
  import vend_pkg::*;
#(
  parameter int                         SUM_W       = 8,
  parameter int                         N_DRINK     = 2,
  parameter logic [N_DRINK*SUM_W-1:0]   PRICE_VEC   = {8'd10, 8'd5},
  parameter int                         MAX_SUM     = 40,
  parameter int                         DISP_CYC    = 4,
  parameter int                         TIMEOUT_CYC = 0
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          insert,
  input  logic [1:0]                                    coin_val,
  input  logic [((N_DRINK > 1) ? $clog2(N_DRINK) : 1)-1:0] drink_op,
  input  logic                                          buy,
  input  logic                                          cancel_flag,
  output logic                                          hold_ind,
  output logic [N_DRINK-1:0]                            drink_ind,
  output logic                                          drinktk_ind,
  output logic                                          charge_ind,
  output logic                                          coin_rej,
  output logic [SUM_W-1:0]                              coin_sum
`ifdef CHANGE_PAYOUT_EN
  ,
  output logic                                          pay_1,
  output logic                                          pay_half
`endif
);

  localparam int TMR_MAX = (DISP_CYC > TIMEOUT_CYC) ? DISP_CYC : TIMEOUT_CYC;
  localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] DISP_LOAD = TMR_W'((DISP_CYC > 0) ? DISP_CYC - 1 : 0);
  localparam logic [TMR_W-1:0] TO_LOAD   = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic             TO_EN     = (TIMEOUT_CYC > 0);
  localparam logic [SUM_W:0]   MAX_Q     = (SUM_W+1)'(MAX_SUM);

  state_t           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d, price_sel;
  logic [SUM_W:0]   sum_ext;
  logic             coin_fits, op_valid, buy_ok;
  logic             coin_rej_q, rej_d;
  logic             disp_load, disp_zero, to_load, to_zero;

  vend_timer #(.W(TMR_W)) u_disp_timer (
    .clk(clk), .rst(rst), .load(disp_load), .load_val(DISP_LOAD), .zero(disp_zero)
  );

  vend_timer #(.W(TMR_W)) u_idle_timer (
    .clk(clk), .rst(rst), .load(to_load), .load_val(TO_LOAD), .zero(to_zero)
  );

  // One bit wider than the credit so an oversized coin is detected rather than wrapped.
  assign sum_ext   = {1'b0, sum_q} + (SUM_W+1)'(coin_q(coin_val));
  assign coin_fits = (sum_ext <= MAX_Q);

  always_comb begin
    price_sel = '0;
    op_valid  = 1'b0;
    for (int i = 0; i < N_DRINK; i++) begin
      if (int'(drink_op) == i) begin
        price_sel = PRICE_VEC[i*SUM_W +: SUM_W];
        op_valid  = 1'b1;
      end
    end
  end

  assign buy_ok = buy && op_valid && (sum_q >= price_sel);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    rej_d     = 1'b0;
    disp_load = 1'b0;
    to_load   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (insert) begin
          if (coin_fits) begin
            sum_d   = sum_ext[SUM_W-1:0];
            state_d = ST_COLLECT;
            to_load = 1'b1;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (cancel_flag) begin
          state_d   = ST_CHANGE;
          disp_load = 1'b1;
          rej_d     = insert;
        end else if (buy_ok) begin
          sum_d     = sum_q - price_sel;
          state_d   = ST_VEND;
          disp_load = 1'b1;
          to_load   = 1'b1;
          rej_d     = insert;
        end else if (insert && coin_fits) begin
          sum_d   = sum_ext[SUM_W-1:0];
          to_load = 1'b1;
        end else begin
          rej_d = insert;
          if (TO_EN && to_zero) begin
            state_d   = ST_CHANGE;
            disp_load = 1'b1;
          end
        end
      end
      ST_VEND: begin
        rej_d = insert;
        if (disp_zero) begin
          if (sum_q != '0) begin
            state_d   = ST_CHANGE;
            disp_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        rej_d = insert;
`ifdef CHANGE_PAYOUT_EN
        if (sum_q >= SUM_W'(2))  sum_d = sum_q - SUM_W'(2);
        else if (sum_q != '0)    sum_d = sum_q - SUM_W'(1);
        else                     state_d = ST_IDLE;
`else
        if (disp_zero) begin
          sum_d   = '0;
          state_d = ST_IDLE;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sum_q      <= '0;
      coin_rej_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      coin_rej_q <= rej_d;
    end
  end

  always_comb begin
    drink_ind = '0;
    for (int i = 0; i < N_DRINK; i++)
      drink_ind[i] = (state_q == ST_COLLECT) && (sum_q >= PRICE_VEC[i*SUM_W +: SUM_W]);
  end

  assign hold_ind    = (state_q != ST_IDLE);
  assign drinktk_ind = (state_q == ST_VEND);
  assign charge_ind  = (state_q == ST_CHANGE);
  assign coin_rej    = coin_rej_q;
  assign coin_sum    = sum_q;

`ifdef CHANGE_PAYOUT_EN
  assign pay_1    = (state_q == ST_CHANGE) && (sum_q >= SUM_W'(2));
  assign pay_half = (state_q == ST_CHANGE) && (sum_q == SUM_W'(1));
`endif

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed bench for vend_ctrl_param: default instance plus a TIMEOUT_CYC=16 instance on shared inputs.
module tb_vend_ctrl_param;

  logic       clk = 1'b0;
  logic       rst, insert, buy, cancel_flag;
  logic [1:0] coin_val;
  logic [0:0] drink_op;

  logic       hold_ind, drinktk_ind, charge_ind, coin_rej;
  logic [1:0] drink_ind;
  logic [7:0] coin_sum;
  logic       hold_t, drinktk_t, charge_t, coin_rej_t;
  logic [1:0] drink_t;
  logic [7:0] sum_t;
`ifdef CHANGE_PAYOUT_EN
  logic       pay_1, pay_half, pay_1_t, pay_half_t;
`endif

  int errors = 0;
  int checks = 0;

  vend_ctrl_param dut (
    .clk(clk), .rst(rst), .insert(insert), .coin_val(coin_val), .drink_op(drink_op),
    .buy(buy), .cancel_flag(cancel_flag), .hold_ind(hold_ind), .drink_ind(drink_ind),
    .drinktk_ind(drinktk_ind), .charge_ind(charge_ind), .coin_rej(coin_rej), .coin_sum(coin_sum)
`ifdef CHANGE_PAYOUT_EN
    , .pay_1(pay_1), .pay_half(pay_half)
`endif
  );

  vend_ctrl_param #(.TIMEOUT_CYC(16)) dut_to (
    .clk(clk), .rst(rst), .insert(insert), .coin_val(coin_val), .drink_op(drink_op),
    .buy(buy), .cancel_flag(cancel_flag), .hold_ind(hold_t), .drink_ind(drink_t),
    .drinktk_ind(drinktk_t), .charge_ind(charge_t), .coin_rej(coin_rej_t), .coin_sum(sum_t)
`ifdef CHANGE_PAYOUT_EN
    , .pay_1(pay_1_t), .pay_half(pay_half_t)
`endif
  );

  always #5 clk = ~clk;

  // Observed status packed as {hold, drinktk, charge, coin_rej, drink_ind, coin_sum}.
  logic [13:0] obs, obs_t;
  assign obs   = {hold_ind, drinktk_ind, charge_ind, coin_rej, drink_ind, coin_sum};
  assign obs_t = {hold_t, drinktk_t, charge_t, coin_rej_t, drink_t, sum_t};

  function automatic logic [13:0] st(input logic h, input logic d, input logic c, input logic r,
                                      input logic [1:0] di, input logic [7:0] s);
    return {h, d, c, r, di, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    insert = 1'b0; buy = 1'b0; cancel_flag = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic coin(input logic [1:0] v);
    insert = 1'b1; coin_val = v;
    tick();
    insert = 1'b0;
  endtask

  task automatic purchase(input logic [0:0] op);
    buy = 1'b1; drink_op = op;
    tick();
    buy = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== st(0, 0, 0, 0, 2'b00, 8'd0)) begin
      errors++; $display("FAIL reset_state: got %h, expected %h", obs, st(0, 0, 0, 0, 2'b00, 8'd0));
    end
    coin(2'b11);
    do_reset();
    checks++;
    if (obs !== st(0, 0, 0, 0, 2'b00, 8'd0)) begin
      errors++; $display("FAIL reset_discards_credit: got %h, expected %h", obs, st(0, 0, 0, 0, 2'b00, 8'd0));
    end
  endtask

  task automatic test_buy_change();
    do_reset();
    repeat (3) coin(2'b01);
    checks++;
    if (obs !== st(1, 0, 0, 0, 2'b01, 8'd6)) begin
      errors++; $display("FAIL collect_sum6: got %h, expected %h", obs, st(1, 0, 0, 0, 2'b01, 8'd6));
    end
    purchase(1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs !== st(1, 1, 0, 0, 2'b00, 8'd1)) begin
        errors++; $display("FAIL vend_cycle%0d: got %h, expected %h", k, obs, st(1, 1, 0, 0, 2'b00, 8'd1));
      end
      tick();
    end
`ifdef CHANGE_PAYOUT_EN
    checks++;
    if ({obs, pay_1, pay_half} !== {st(1, 0, 1, 0, 2'b00, 8'd1), 2'b01}) begin
      errors++; $display("FAIL payout_half: got %h, expected %h", {obs, pay_1, pay_half}, {st(1, 0, 1, 0, 2'b00, 8'd1), 2'b01});
    end
    tick();
    checks++;
    if ({obs, pay_1, pay_half} !== {st(1, 0, 1, 0, 2'b00, 8'd0), 2'b00}) begin
      errors++; $display("FAIL payout_done: got %h, expected %h", {obs, pay_1, pay_half}, {st(1, 0, 1, 0, 2'b00, 8'd0), 2'b00});
    end
    tick();
`else
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs !== st(1, 0, 1, 0, 2'b00, 8'd1)) begin
        errors++; $display("FAIL change_cycle%0d: got %h, expected %h", k, obs, st(1, 0, 1, 0, 2'b00, 8'd1));
      end
      tick();
    end
`endif
    checks++;
    if (obs !== st(0, 0, 0, 0, 2'b00, 8'd0)) begin
      errors++; $display("FAIL idle_after_change: got %h, expected %h", obs, st(0, 0, 0, 0, 2'b00, 8'd0));
    end
  endtask

  task automatic test_exact_buy();
    do_reset();
    coin(2'b10);
    checks++;
    if (obs !== st(1, 0, 0, 0, 2'b11, 8'd10)) begin
      errors++; $display("FAIL collect_sum10: got %h, expected %h", obs, st(1, 0, 0, 0, 2'b11, 8'd10));
    end
    purchase(1'b1);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs !== st(1, 1, 0, 0, 2'b00, 8'd0)) begin
        errors++; $display("FAIL exact_vend%0d: got %h, expected %h", k, obs, st(1, 1, 0, 0, 2'b00, 8'd0));
      end
      tick();
    end
    checks++;
    if (obs !== st(0, 0, 0, 0, 2'b00, 8'd0)) begin
      errors++; $display("FAIL exact_no_change: got %h, expected %h", obs, st(0, 0, 0, 0, 2'b00, 8'd0));
    end
  endtask

  task automatic test_overflow();
    do_reset();
    coin(2'b11);
    coin(2'b11);
    checks++;
    if (obs !== st(1, 0, 0, 0, 2'b11, 8'd40)) begin
      errors++; $display("FAIL max_credit: got %h, expected %h", obs, st(1, 0, 0, 0, 2'b11, 8'd40));
    end
    coin(2'b00);
    checks++;
    if (obs !== st(1, 0, 0, 1, 2'b11, 8'd40)) begin
      errors++; $display("FAIL overflow_reject: got %h, expected %h", obs, st(1, 0, 0, 1, 2'b11, 8'd40));
    end
    tick();
    checks++;
    if (obs !== st(1, 0, 0, 0, 2'b11, 8'd40)) begin
      errors++; $display("FAIL reject_one_cycle: got %h, expected %h", obs, st(1, 0, 0, 0, 2'b11, 8'd40));
    end
  endtask

  task automatic test_priority();
    do_reset();
    purchase(1'b0);
    cancel_flag = 1'b1;
    tick();
    cancel_flag = 1'b0;
    checks++;
    if (obs !== st(0, 0, 0, 0, 2'b00, 8'd0)) begin
      errors++; $display("FAIL idle_ignores_buy_cancel: got %h, expected %h", obs, st(0, 0, 0, 0, 2'b00, 8'd0));
    end
    coin(2'b01);
    cancel_flag = 1'b1; buy = 1'b1; drink_op = 1'b0;
    tick();
    clear_inputs();
    checks++;
    if (obs !== st(1, 0, 1, 0, 2'b00, 8'd2)) begin
      errors++; $display("FAIL cancel_refund2: got %h, expected %h", obs, st(1, 0, 1, 0, 2'b00, 8'd2));
    end
    do_reset();
    coin(2'b10);
    cancel_flag = 1'b1; buy = 1'b1; drink_op = 1'b0; insert = 1'b1; coin_val = 2'b01;
    tick();
    clear_inputs();
    checks++;
    if (obs !== st(1, 0, 1, 1, 2'b00, 8'd10)) begin
      errors++; $display("FAIL cancel_beats_buy_insert: got %h, expected %h", obs, st(1, 0, 1, 1, 2'b00, 8'd10));
    end
  endtask

  task automatic test_timeout();
    logic [7:0] rej_sum;
`ifdef CHANGE_PAYOUT_EN
    rej_sum = 8'd2;
`else
    rej_sum = 8'd4;
`endif
    do_reset();
    coin(2'b01);
    repeat (15) tick();
    checks++;
    if (obs_t !== st(1, 0, 0, 0, 2'b00, 8'd2)) begin
      errors++; $display("FAIL timeout_not_early: got %h, expected %h", obs_t, st(1, 0, 0, 0, 2'b00, 8'd2));
    end
    tick();
    checks++;
    if (obs_t !== st(1, 0, 1, 0, 2'b00, 8'd2)) begin
      errors++; $display("FAIL timeout_refund: got %h, expected %h", obs_t, st(1, 0, 1, 0, 2'b00, 8'd2));
    end
    checks++;
    if (obs !== st(1, 0, 0, 0, 2'b00, 8'd2)) begin
      errors++; $display("FAIL no_timeout_default: got %h, expected %h", obs, st(1, 0, 0, 0, 2'b00, 8'd2));
    end
    do_reset();
    coin(2'b01);
    repeat (9) tick();
    coin(2'b01);
    repeat (15) tick();
    checks++;
    if (obs_t !== st(1, 0, 0, 0, 2'b00, 8'd4)) begin
      errors++; $display("FAIL timeout_restart: got %h, expected %h", obs_t, st(1, 0, 0, 0, 2'b00, 8'd4));
    end
    tick();
    checks++;
    if (obs_t !== st(1, 0, 1, 0, 2'b00, 8'd4)) begin
      errors++; $display("FAIL timeout_refund4: got %h, expected %h", obs_t, st(1, 0, 1, 0, 2'b00, 8'd4));
    end
    coin(2'b00);
    checks++;
    if (obs_t !== st(1, 0, 1, 1, 2'b00, rej_sum)) begin
      errors++; $display("FAIL change_insert_reject: got %h, expected %h", obs_t, st(1, 0, 1, 1, 2'b00, rej_sum));
    end
  endtask

`ifdef CHANGE_PAYOUT_EN
  task automatic test_payout();
    logic [1:0] exp_pay [4] = '{2'b10, 2'b10, 2'b01, 2'b00};
    logic [7:0] exp_sum [4] = '{8'd5, 8'd3, 8'd1, 8'd0};
    do_reset();
    coin(2'b10); coin(2'b01); coin(2'b01); coin(2'b00);
    checks++;
    if (obs !== st(1, 0, 0, 0, 2'b11, 8'd15)) begin
      errors++; $display("FAIL collect_sum15: got %h, expected %h", obs, st(1, 0, 0, 0, 2'b11, 8'd15));
    end
    purchase(1'b1);
    repeat (4) tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({obs, pay_1, pay_half} !== {st(1, 0, 1, 0, 2'b00, exp_sum[k]), exp_pay[k]}) begin
        errors++; $display("FAIL payout_step%0d: got %h, expected %h", k, {obs, pay_1, pay_half},
                           {st(1, 0, 1, 0, 2'b00, exp_sum[k]), exp_pay[k]});
      end
      tick();
    end
    checks++;
    if (obs !== st(0, 0, 0, 0, 2'b00, 8'd0)) begin
      errors++; $display("FAIL payout_idle: got %h, expected %h", obs, st(0, 0, 0, 0, 2'b00, 8'd0));
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; coin_val = 2'b00; drink_op = 1'b0;
    clear_inputs();
    test_reset();
    test_buy_change();
    test_exact_buy();
    test_overflow();
    test_priority();
    test_timeout();
`ifdef CHANGE_PAYOUT_EN
    test_payout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
